// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: loader state encoding,
// instruction width and the all-zero NOOP word.
package imem_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOOP = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs big-endian stream bytes into 32-bit instruction words and keeps the
// running XOR of every data byte for the trailing checksum compare.
import imem_pkg::*;

module imem_word_assembler (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               shift_en,
    input  logic               idx_clr,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word_nxt,
    output logic [7:0]         chk,
    output logic               last_byte,
    output logic               word_ready
);

    logic [INSTR_W-1:0] word_q;
    logic [2:0]         idx_q;
    logic [7:0]         chk_q;

    // First byte of a word ends up in bits 31:24 after four shifts.
    assign word_nxt   = {word_q[INSTR_W-9:0], byte_in};
    assign chk        = chk_q;
    assign last_byte  = (idx_q == 3'd3);
    assign word_ready = (idx_q == 3'd4);

    // Shift register, byte index and checksum accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= NOOP;
            idx_q  <= 3'd0;
            chk_q  <= 8'h00;
        end else if (clr) begin
            word_q <= NOOP;
            idx_q  <= 3'd0;
            chk_q  <= 8'h00;
        end else begin
            if (idx_clr) begin
                idx_q <= 3'd0;
            end
            if (shift_en) begin
                word_q <= word_nxt;
                idx_q  <= idx_q + 3'd1;
                chk_q  <= chk_q ^ byte_in;
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-serial program loader: parses a count/data/checksum frame, writes each
// assembled instruction into the instruction RAM and holds the CPU in reset
// while a load is in progress.
import imem_pkg::*;

module imem_loader #(
    parameter int          DEPTH     = 64,
    parameter int          ADDR_W    = 32,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               busy,
    output logic               cpu_hold,
    output logic               done,
    output logic               error
);

    state_t             state_q, state_d;
    logic [15:0]        cnt_q;
    logic [ADDR_W-1:0]  word_idx_q;
    logic [ADDR_W-1:0]  idx_inc;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [INSTR_W-1:0] wr_data_q;
    logic [15:0]        hdr_cnt;

    logic               asm_clr;
    logic               shift_en;
    logic               idx_clr;
    logic [INSTR_W-1:0] word_nxt;
    logic [7:0]         chk;
    logic               last_byte;
    logic               word_ready;

    assign hdr_cnt  = {cnt_q[15:8], in_data};
    assign idx_inc  = word_idx_q + ADDR_W'(1);
    assign cpu_hold = busy;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

    imem_word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (asm_clr),
        .shift_en  (shift_en),
        .idx_clr   (idx_clr),
        .byte_in   (in_data),
        .word_nxt  (word_nxt),
        .chk       (chk),
        .last_byte (last_byte),
        .word_ready(word_ready)
    );

    // Loader state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and per-state outputs; in_ready gates every byte transfer.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b1;
        wr_en    = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        asm_clr  = 1'b0;
        shift_en = 1'b0;
        idx_clr  = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = HDR_HI;
                    asm_clr = 1'b1;
                end
            end
            HDR_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (32'(hdr_cnt) > 32'(DEPTH)) begin
                        state_d = ERR;
                    end else if (hdr_cnt == 16'd0) begin
                        state_d = CHK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_en = 1'b1;
                    if (last_byte) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                wr_en   = word_ready;
                idx_clr = 1'b1;
                state_d = (idx_inc == ADDR_W'(cnt_q)) ? CHK : DATA;
            end
            CHK: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (in_data == chk) ? DONE : ERR;
                end
            end
            DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (start) begin
                    state_d = HDR_HI;
                    asm_clr = 1'b1;
                end
            end
            ERR: begin
                busy  = 1'b0;
                error = 1'b1;
                if (start) begin
                    state_d = HDR_HI;
                    asm_clr = 1'b1;
                end
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Frame count, word index and the write-port address/data holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= 16'd0;
            word_idx_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= NOOP;
        end else if (asm_clr) begin
            cnt_q      <= 16'd0;
            word_idx_q <= '0;
        end else begin
            if (state_q == HDR_HI && in_valid) begin
                cnt_q[15:8] <= in_data;
            end
            if (state_q == HDR_LO && in_valid) begin
                cnt_q[7:0] <= in_data;
            end
            if (shift_en && last_byte) begin
                wr_data_q <= word_nxt;
                wr_addr_q <= ADDR_W'(BASE_ADDR) + word_idx_q;
            end
            if (state_q == WRITE) begin
                word_idx_q <= idx_inc;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: randomized framed loads against a frame-level model.
module tb_imem_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              busy;
    logic              cpu_hold;
    logic              done;
    logic              error;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy),
        .cpu_hold(cpu_hold),
        .done    (done),
        .error   (error)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Frame-level model: expected writes and position of the current byte in the frame.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    int          m_cnt   = 0;
    bit          m_legal = 1'b0;
    int          m_pos   = 0;
    bit          exp_wr_next = 1'b0;

    // Per-cycle compare, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_wr_next = 1'b0;
            m_pos       = 0;
        end else begin
            check("wr_en", wr_en, exp_wr_next);
            if (wr_en) begin
                log_addr.push_back(wr_addr);
                log_data.push_back(wr_data);
                if (exp_wr.size() > 0) begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", wr_addr, e.addr);
                    check("wr_data", wr_data, e.data);
                end else begin
                    fail_now("wr_unexpected");
                end
            end
            check("cpu_hold", cpu_hold, busy);
            check("in_ready", in_ready, busy && !wr_en);
            exp_wr_next = 1'b0;
            if (start && !busy) begin
                m_pos = 0;
            end else if (in_valid && in_ready) begin
                int d;
                d = m_pos - 2;
                if (m_legal && m_pos >= 2 && d < 4 * m_cnt && (d % 4) == 3)
                    exp_wr_next = 1'b1;
                m_pos++;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap, input bit poke);
        int  g;
        bit  acc;
        bit  got;
        g = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        for (int i = 0; i < g; i++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            start    = poke && busy && ($urandom_range(3, 0) == 0);
            @(posedge clk); #1;
            start    = 1'b0;
        end
        in_valid = 1'b1;
        in_data  = b;
        got      = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) got = 1'b1;
        end
        in_valid = 1'b0;
        if (!got) fail_now("accept_timeout");
    endtask

    task automatic mk_frame(input int cnt, input bit bad, output logic [7:0] q[$]);
        logic [7:0] x;
        logic [7:0] b;
        logic [15:0] c;
        q.delete();
        c = 16'(cnt);
        q.push_back(c[15:8]);
        q.push_back(c[7:0]);
        x = 8'h00;
        for (int i = 0; i < 4 * cnt; i++) begin
            b = 8'($urandom);
            q.push_back(b);
            x ^= b;
        end
        if (bad) x ^= 8'($urandom_range(255, 1));
        q.push_back(x);
    endtask

    // Run one frame; the model derives writes and final status from the bytes.
    task automatic run_frame(input logic [7:0] q[$], input int max_gap, input bit poke);
        int         cnt;
        bit         legal;
        logic [7:0] x;
        bit         e_done;
        int         n_send;
        wr_t        w;
        cnt   = {q[0], q[1]};
        legal = (cnt <= DEPTH);
        x     = 8'h00;
        exp_wr.delete();
        log_addr.delete();
        log_data.delete();
        if (legal) begin
            for (int i = 0; i < cnt; i++) begin
                w.addr = 32'(i);
                w.data = {q[2+4*i], q[3+4*i], q[4+4*i], q[5+4*i]};
                exp_wr.push_back(w);
            end
            for (int i = 2; i < 2 + 4 * cnt; i++) x ^= q[i];
        end
        e_done  = legal && (q.size() == 3 + 4 * cnt) && (q[2 + 4 * cnt] == x);
        n_send  = legal ? q.size() : 2;
        m_cnt   = cnt;
        m_legal = legal;
        pulse_start();
        check("busy_after_start", busy, 1'b1);
        for (int i = 0; i < n_send; i++) send_byte(q[i], max_gap, poke);
        for (int i = 0; i < 50 && busy; i++) begin
            @(posedge clk); #1;
        end
        check("busy_end", busy, 1'b0);
        check("done_end", done, e_done);
        check("error_end", error, !e_done);
        check("in_ready_end", in_ready, 1'b0);
        check("writes_left", exp_wr.size(), 0);
    endtask

    logic [7:0] basic[$];
    logic [7:0] fr[$];

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        basic    = '{8'h00, 8'h02, 8'hE4, 8'h00, 8'hFF, 8'hFF,
                     8'hE8, 8'h00, 8'hFF, 8'hFF, 8'h0C};
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_wr_en", wr_en, 1'b0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_cpu_hold", cpu_hold, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        rst = 1'b0;

        // Bytes offered while idle must be ignored.
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("idle_busy", busy, 1'b0);

        // Basic load with literal expectations.
        run_frame(basic, 0, 1'b0);
        check("basic_nwr", log_data.size(), 2);
        check("basic_a0", log_addr[0], 32'd0);
        check("basic_d0", log_data[0], 32'hE400FFFF);
        check("basic_a1", log_addr[1], 32'd1);
        check("basic_d1", log_data[1], 32'hE800FFFF);
        check("basic_done", done, 1'b1);
        check("basic_hold", cpu_hold, 1'b0);

        // Bad checksum.
        fr = basic;
        fr[10] = 8'h0D;
        run_frame(fr, 0, 1'b0);
        check("badchk_nwr", log_data.size(), 2);
        check("badchk_err", error, 1'b1);
        check("badchk_done", done, 1'b0);

        // Empty frames.
        fr = '{8'h00, 8'h00, 8'h00};
        run_frame(fr, 1, 1'b0);
        check("empty_nwr", log_data.size(), 0);
        check("empty_done", done, 1'b1);
        fr = '{8'h00, 8'h00, 8'h01};
        run_frame(fr, 1, 1'b0);
        check("empty_bad_err", error, 1'b1);

        // Oversize counts: DEPTH+1 and a count that needs the high byte.
        fr = '{8'h00, 8'h41};
        run_frame(fr, 0, 1'b0);
        check("over_nwr", log_data.size(), 0);
        check("over_err", error, 1'b1);
        check("over_rdy", in_ready, 1'b0);
        fr = '{8'h01, 8'h00};
        run_frame(fr, 2, 1'b0);
        check("over_hi_err", error, 1'b1);

        // Backpressure with stray start pulses while busy.
        run_frame(basic, 3, 1'b1);
        check("bp_nwr", log_data.size(), 2);
        check("bp_d0", log_data[0], 32'hE400FFFF);
        check("bp_d1", log_data[1], 32'hE800FFFF);
        check("bp_done", done, 1'b1);

        // Full-depth frame.
        mk_frame(DEPTH, 1'b0, fr);
        run_frame(fr, 1, 1'b0);
        check("full_nwr", log_data.size(), DEPTH);
        check("full_last_addr", log_addr[DEPTH-1], 32'(DEPTH - 1));
        check("full_done", done, 1'b1);

        // Random frames.
        for (int k = 0; k < 12; k++) begin
            mk_frame($urandom_range(6, 0), ($urandom_range(3, 0) == 0), fr);
            run_frame(fr, $urandom_range(3, 0), 1'b1);
        end

        // Reset mid-frame after two data bytes.
        exp_wr.delete();
        m_cnt   = 2;
        m_legal = 1'b1;
        pulse_start();
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h02, 0, 1'b0);
        send_byte(8'h12, 0, 1'b0);
        send_byte(8'h34, 0, 1'b0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_wr_en", wr_en, 1'b0);
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_wr_data", wr_data, 0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_hold", cpu_hold, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_error", error, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_frame(basic, 2, 1'b0);
        check("post_rst_nwr", log_data.size(), 2);
        check("post_rst_a0", log_addr[0], 32'd0);
        check("post_rst_d1", log_data[1], 32'hE800FFFF);
        check("post_rst_done", done, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
